// File: rtl/mp_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mp_add_seq_if
// Brief    : Request, external-adder and result bundle for mp_add_seq.
// Revision : 1.0
// ============================================================================
interface mp_add_seq_if #(
    parameter int N     = 32,
    parameter int WORDS = 4
);
    logic                 start_valid;
    logic                 start_ready;
    logic [N*WORDS-1:0]   op_a;
    logic [N*WORDS-1:0]   op_b;
    logic                 op_sub;
    logic                 op_cin;
    logic [N-1:0]         add_a;
    logic [N-1:0]         add_b;
    logic                 add_cin;
    logic [N-1:0]         add_s;
    logic                 add_cout;
    logic                 res_valid;
    logic                 res_ready;
    logic [N*WORDS-1:0]   res_sum;
    logic                 res_cout;
    logic                 res_ovf;

    // master: requester plus the external adder; slave: the sequencer
    modport master (
        output start_valid, op_a, op_b, op_sub, op_cin, add_s, add_cout, res_ready,
        input  start_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout, res_ovf
    );

    modport slave (
        input  start_valid, op_a, op_b, op_sub, op_cin, add_s, add_cout, res_ready,
        output start_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout, res_ovf
    );
endinterface
`default_nettype wire

// File: rtl/mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : mp_add_seq
// Brief    : Multi-precision add/subtract sequencer driving one N-bit adder.
// Revision : 1.0
// ============================================================================
module mp_add_seq #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    mp_add_seq_if.slave bus
);
    localparam int c_W  = N * WORDS;
    localparam int c_IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [c_W-1:0]    r_a;
    logic [c_W-1:0]    r_b;
    logic [c_W-1:0]    r_sum;
    logic [c_IW-1:0]   r_idx;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic              w_run;
    logic              w_last;
    logic [N-1:0]      w_word_a;
    logic [N-1:0]      w_word_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start_valid) w_next = S_RUN;
            S_RUN:   if (w_last)          w_next = S_DONE;
            S_DONE:  if (bus.res_ready)   w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    assign w_run    = (r_state == S_RUN);
    assign w_last   = (r_idx == c_LAST);
    assign w_word_a = r_a[int'(r_idx) * N +: N];
    assign w_word_b = r_b[int'(r_idx) * N +: N];

    // B is stored pre-inverted for subtract so RUN never needs to know the opcode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        r_a     <= bus.op_a;
                        r_b     <= bus.op_b ^ {c_W{bus.op_sub}};
                        r_carry <= bus.op_sub | bus.op_cin;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[int'(r_idx) * N +: N] <= bus.add_s;
                    r_carry <= bus.add_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= bus.add_cout;
                        r_ovf  <= (r_a[c_W-1] == r_b[c_W-1]) &
                                  (bus.add_s[N-1] != r_a[c_W-1]);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.start_ready = (r_state == S_IDLE);
    assign bus.res_valid   = (r_state == S_DONE);
    assign bus.add_a       = w_run ? w_word_a : '0;
    assign bus.add_b       = w_run ? w_word_b : '0;
    assign bus.add_cin     = w_run & r_carry;
    assign bus.res_sum     = r_sum;
    assign bus.res_cout    = r_cout;
    assign bus.res_ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mp_add_seq
// Brief    : Scoreboard bench for mp_add_seq (WORDS=4 and WORDS=1 instances).
// Revision : 1.0
// ============================================================================
module tb_mp_add_seq;
    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int WD    = N * WORDS;

    typedef struct {
        logic [WD-1:0] sum;
        logic          cout;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;
    exp_t q[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    mp_add_seq_if #(.N(N), .WORDS(WORDS)) bus ();
    mp_add_seq_if #(.N(N), .WORDS(1))     bus1 ();

    mp_add_seq #(.N(N), .WORDS(WORDS)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mp_add_seq #(.N(N), .WORDS(1))     dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // external ripple-carry adders
    assign {bus.add_cout, bus.add_s} =
        {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{N{1'b0}}, bus.add_cin};
    assign {bus1.add_cout, bus1.add_s} =
        {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {{N{1'b0}}, bus1.add_cin};

    function automatic exp_t model(input logic [WD-1:0] a, input logic [WD-1:0] b,
                                   input logic sub, input logic cin);
        logic [WD-1:0] bp;
        logic [WD:0]   t;
        exp_t          e;
        bp     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bp} + {{WD{1'b0}}, (sub | cin)};
        e.sum  = t[WD-1:0];
        e.cout = t[WD];
        e.ovf  = (a[WD-1] == bp[WD-1]) && (t[WD-1] != a[WD-1]);
        return e;
    endfunction

    task automatic issue(input logic [WD-1:0] a, input logic [WD-1:0] b,
                         input logic sub, input logic cin, input bit push, input string tag);
        logic [WD-1:0] bp;
        bp = sub ? ~b : b;
        bus.op_a = a; bus.op_b = b; bus.op_sub = sub; bus.op_cin = cin;
        bus.start_valid = 1'b1;
        n_chk++;
        if (bus.start_ready !== 1'b1) $display("FAIL %s_ready: got %b want 1", tag, bus.start_ready);
        else n_pass++;
        if (push) q.push_back(model(a, b, sub, cin));
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        n_chk++;
        if ({bus.add_cin, bus.add_b, bus.add_a} !== {(sub | cin), bp[N-1:0], a[N-1:0]})
            $display("FAIL %s_word0: got cin=%b b=%h a=%h want cin=%b b=%h a=%h", tag,
                     bus.add_cin, bus.add_b, bus.add_a, (sub | cin), bp[N-1:0], a[N-1:0]);
        else n_pass++;
    endtask

    task automatic collect(input int lat, input string tag);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (bus.res_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_chk++;
        if (cyc !== lat) $display("FAIL %s_latency: got %0d want %0d", tag, cyc, lat);
        else n_pass++;
        n_chk++;
        if (q.size() == 0) begin
            $display("FAIL %s_scoreboard: got empty queue want entry", tag);
            return;
        end
        n_pass++;
        e = q.pop_front();
        n_chk++;
        if ({bus.res_sum, bus.res_cout, bus.res_ovf} !== {e.sum, e.cout, e.ovf})
            $display("FAIL %s_result: got sum=%h c=%b v=%b want sum=%h c=%b v=%b", tag,
                     bus.res_sum, bus.res_cout, bus.res_ovf, e.sum, e.cout, e.ovf);
        else n_pass++;
    endtask

    task automatic release_res(input string tag);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        n_chk++;
        if ({bus.start_ready, bus.res_valid} !== 2'b10)
            $display("FAIL %s_release: got ready=%b valid=%b want ready=1 valid=0", tag,
                     bus.start_ready, bus.res_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({bus.start_ready, bus.res_valid} !== 2'b10)
            $display("FAIL reset_hs: got ready=%b valid=%b want 1/0", bus.start_ready, bus.res_valid);
        else n_pass++;
        n_chk++;
        if ({bus.res_sum, bus.res_cout, bus.res_ovf} !== {(WD + 2){1'b0}})
            $display("FAIL reset_res: got sum=%h c=%b v=%b want 0", bus.res_sum, bus.res_cout, bus.res_ovf);
        else n_pass++;
        n_chk++;
        if ({bus.add_a, bus.add_b, bus.add_cin} !== {(2 * N + 1){1'b0}})
            $display("FAIL reset_adder: got a=%h b=%h cin=%b want 0", bus.add_a, bus.add_b, bus.add_cin);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_carry_chain();
        issue({WD{1'b1}}, WD'(1), 1'b0, 1'b0, 1'b1, "carry");
        collect(WORDS, "carry");
        n_chk++;
        if ({bus.res_sum, bus.res_cout, bus.res_ovf} !== {{WD{1'b0}}, 1'b1, 1'b0})
            $display("FAIL carry_const: got sum=%h c=%b v=%b want 0/1/0", bus.res_sum, bus.res_cout, bus.res_ovf);
        else n_pass++;
        release_res("carry");
    endtask

    task automatic test_sub_borrow();
        issue({WD{1'b0}}, WD'(1), 1'b1, 1'b0, 1'b1, "sub");
        collect(WORDS, "sub");
        n_chk++;
        if ({bus.res_sum, bus.res_cout, bus.res_ovf} !== {{WD{1'b1}}, 1'b0, 1'b0})
            $display("FAIL sub_const: got sum=%h c=%b v=%b want ff..ff/0/0", bus.res_sum, bus.res_cout, bus.res_ovf);
        else n_pass++;
        release_res("sub");
    endtask

    task automatic test_overflow();
        issue({1'b0, {(WD - 1){1'b1}}}, WD'(1), 1'b0, 1'b0, 1'b1, "ovf");
        collect(WORDS, "ovf");
        n_chk++;
        if ({bus.res_sum, bus.res_cout, bus.res_ovf} !== {1'b1, {(WD - 1){1'b0}}, 1'b0, 1'b1})
            $display("FAIL ovf_const: got sum=%h c=%b v=%b want 80..00/0/1", bus.res_sum, bus.res_cout, bus.res_ovf);
        else n_pass++;
        release_res("ovf");
    endtask

    task automatic test_random();
        logic [WD-1:0] a;
        logic [WD-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            if (i == 2) b = ~a;
            issue(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, "rand");
            collect(WORDS, "rand");
            release_res("rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [WD-1:0] held;
        logic [WD-1:0] a2;
        logic [WD-1:0] b2;
        issue({4{32'h89AB_CDEF}}, {4{32'h7654_3211}}, 1'b0, 1'b1, 1'b1, "bp");
        collect(WORDS, "bp");
        held = bus.res_sum;
        a2 = {$urandom, $urandom, $urandom, $urandom};
        b2 = {$urandom, $urandom, $urandom, $urandom};
        bus.op_a = a2; bus.op_b = b2; bus.op_sub = 1'b1; bus.op_cin = 1'b0;
        bus.start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({bus.res_valid, bus.start_ready, bus.res_sum} !== {2'b10, held})
                $display("FAIL bp_hold%0d: got valid=%b ready=%b sum=%h want 1/0/%h", i,
                         bus.res_valid, bus.start_ready, bus.res_sum, held);
            else n_pass++;
        end
        q.push_back(model(a2, b2, 1'b1, 1'b0));
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        n_chk++;
        if ({bus.start_ready, bus.res_sum} !== {1'b1, held})
            $display("FAIL bp_idle: got ready=%b sum=%h want 1/%h", bus.start_ready, bus.res_sum, held);
        else n_pass++;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        n_chk++;
        if ({bus.start_ready, bus.add_a} !== {1'b0, a2[N-1:0]})
            $display("FAIL bp_accept2: got ready=%b a=%h want 0/%h", bus.start_ready, bus.add_a, a2[N-1:0]);
        else n_pass++;
        collect(WORDS, "bp2");
        release_res("bp2");
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        issue({4{32'hDEAD_BEEF}}, {4{32'h1234_5678}}, 1'b0, 1'b0, 1'b0, "rmr");
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start_valid = 1'b0;
        n_chk++;
        if ({bus.start_ready, bus.res_valid, bus.add_a, bus.res_sum} !== {2'b10, {N{1'b0}}, {WD{1'b0}}})
            $display("FAIL rmr_state: got ready=%b valid=%b a=%h sum=%h want 1/0/0/0",
                     bus.start_ready, bus.res_valid, bus.add_a, bus.res_sum);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) $display("FAIL rmr_novalid: got res_valid seen=%b want 0", seen);
        else n_pass++;
    endtask

    task automatic test_words1();
        exp_t e;
        int   cyc;
        bus1.op_a = 32'd5; bus1.op_b = 32'd7; bus1.op_sub = 1'b0; bus1.op_cin = 1'b1;
        bus1.start_valid = 1'b1;
        e.sum = 128'd13; e.cout = 1'b0; e.ovf = 1'b0;
        q1.push_back(e);
        @(posedge clk); #1;
        bus1.start_valid = 1'b0;
        cyc = 0;
        while (bus1.res_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_chk++;
        if (cyc !== 1) $display("FAIL w1_latency: got %0d want 1", cyc);
        else n_pass++;
        e = q1.pop_front();
        n_chk++;
        if ({bus1.res_sum, bus1.res_cout, bus1.res_ovf} !== {e.sum[N-1:0], e.cout, e.ovf})
            $display("FAIL w1_result: got sum=%h c=%b v=%b want %h/%b/%b",
                     bus1.res_sum, bus1.res_cout, bus1.res_ovf, e.sum[N-1:0], e.cout, e.ovf);
        else n_pass++;
        bus1.res_ready = 1'b1;
        @(posedge clk); #1;
        bus1.res_ready = 1'b0;
        n_chk++;
        if (bus1.start_ready !== 1'b1) $display("FAIL w1_release: got %b want 1", bus1.start_ready);
        else n_pass++;
    endtask

    initial begin
        bus.start_valid  = 1'b0; bus.op_a  = '0; bus.op_b  = '0;
        bus.op_sub       = 1'b0; bus.op_cin = 1'b0; bus.res_ready = 1'b0;
        bus1.start_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0;
        bus1.op_sub      = 1'b0; bus1.op_cin = 1'b0; bus1.res_ready = 1'b0;
        test_reset();
        test_carry_chain();
        test_sub_borrow();
        test_overflow();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_words1();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
